// File: rtl/mem_responder.sv
// Single-outstanding 256x8 memory responder with programmable wait states and a
// write-protected upper address window.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [7:0]  PROT_BASE   = 8'hF0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_req_we,
   input  logic [7:0] i_req_addr,
   input  logic [7:0] i_req_wdata,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_rdata,
   output logic       o_rsp_err,
   output logic       o_busy
);

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_t;

   localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

   state_t     state_q;
   logic [3:0] wait_cnt_q;
   logic       req_we_q;
   logic [7:0] req_addr_q;
   logic [7:0] req_wdata_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_rdata_q;
   logic       rsp_err_q;
   logic [7:0] mem_q [256];

   // Memory contents are deliberately outside the reset branch so reset never alters them.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         wait_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_req_valid) begin
                  req_we_q    <= i_req_we;
                  req_addr_q  <= i_req_addr;
                  req_wdata_q <= i_req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= StAccess;
                  end else begin
                     state_q    <= StWait;
                     wait_cnt_q <= WaitLoad;
                  end
               end
            end
            StWait: begin
               if (wait_cnt_q == 4'd0) begin
                  state_q <= StAccess;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            StAccess: begin
               state_q     <= StResp;
               rsp_valid_q <= 1'b1;
               if (!req_we_q) begin
                  rsp_rdata_q <= mem_q[req_addr_q];
                  rsp_err_q   <= 1'b0;
               end else if (req_addr_q >= PROT_BASE) begin
                  rsp_rdata_q <= 8'h00;
                  rsp_err_q   <= 1'b1;
               end else begin
                  mem_q[req_addr_q] <= req_wdata_q;
                  rsp_rdata_q       <= req_wdata_q;
                  rsp_err_q         <= 1'b0;
               end
            end
            StResp: begin
               if (i_rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_req_ready = (state_q == StIdle);
   assign o_busy      = (state_q != StIdle);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: DUT 0 uses one wait state, DUT 1 uses none with
// response ready tied high.
module tb_mem_responder;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      bit         capture;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
   logic [7:0] req_addr [2];
   logic [7:0] req_wdata [2];
   logic [7:0] rsp_rdata [2];

   exp_t sb_q [2][$];
   int   acc_q [2][$];
   exp_t cur [2];
   bit   cur_active [2];
   bit   hs_pend [2];
   int   acc_cnt [2];
   int   wait_of [2] = '{1, 0};
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [7:0] snapshot = 8'h00;

   always #5 clk = ~clk;

   mem_responder #(.WAIT_CYCLES(1), .PROT_BASE(8'hF0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
      .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
      .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]),
      .o_rsp_err(rsp_err[0]), .o_busy(busy[0])
   );

   mem_responder #(.WAIT_CYCLES(0), .PROT_BASE(8'hF0)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
      .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
      .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]),
      .o_rsp_err(rsp_err[1]), .o_busy(busy[1])
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Edge observer: records accepts and response handshakes using pre-edge values.
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            acc_q[k].delete();
            cur_active[k] = 1'b0;
            hs_pend[k] = 1'b0;
         end else begin
            if (req_valid[k] && req_ready[k]) begin
               acc_q[k].push_back(cyc);
               acc_cnt[k]++;
            end
            if (rsp_valid[k] && rsp_ready[k] && cur_active[k]) begin
               cur_active[k] = 1'b0;
               hs_pend[k] = 1'b1;
            end
         end
      end
   end

   // Monitor: pops expectations on each new response and checks it while it is held.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (hs_pend[k]) begin
            check($sformatf("dut%0d valid_low_after_handshake", k), int'(rsp_valid[k]), 0);
            hs_pend[k] = 1'b0;
         end
         if (rsp_valid[k] && !rst) begin
            if (!cur_active[k]) begin
               if (sb_q[k].size() == 0 || acc_q[k].size() == 0) begin
                  fail_now($sformatf("dut%0d unexpected_response rdata=0x%0h", k, rsp_rdata[k]));
                  cur_active[k] = 1'b0;
               end else begin
                  cur[k] = sb_q[k].pop_front();
                  check($sformatf("dut%0d latency", k), cyc - acc_q[k].pop_front(),
                        wait_of[k] + 1);
                  if (cur[k].capture) snapshot = rsp_rdata[k];
                  cur_active[k] = 1'b1;
               end
            end
            if (cur_active[k]) begin
               if (!cur[k].capture)
                  check($sformatf("dut%0d rdata", k), int'(rsp_rdata[k]), int'(cur[k].rdata));
               check($sformatf("dut%0d err", k), int'(rsp_err[k]), int'(cur[k].err));
               check($sformatf("dut%0d req_ready_in_resp", k), int'(req_ready[k]), 0);
               check($sformatf("dut%0d busy_in_resp", k), int'(busy[k]), 1);
            end
         end
      end
   end

   task automatic drive_a(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_err, input bit capture,
                          input bit expect_rsp);
      exp_t e;
      req_valid[0] = 1'b1;
      req_we[0]    = we;
      req_addr[0]  = addr;
      req_wdata[0] = wdata;
      e.rdata = exp_rdata;
      e.err = exp_err;
      e.capture = capture;
      if (expect_rsp) sb_q[0].push_back(e);
   endtask

   // Waits for the accepting edge, then scrambles the request fields behind it.
   task automatic accept_a();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!req_ready[0] && n < 30);
      if (!req_ready[0]) fail_now("dut0 accept_timeout");
      @(negedge clk);
      req_valid[0] = 1'b0;
      req_we[0]    = 1'($urandom);
      req_addr[0]  = 8'($urandom);
      req_wdata[0] = 8'($urandom);
   endtask

   task automatic issue_a(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_err, input bit capture);
      @(negedge clk);
      drive_a(we, addr, wdata, exp_rdata, exp_err, capture, 1'b1);
      accept_a();
   endtask

   task automatic drain(input int k);
      int n = 0;
      while ((sb_q[k].size() != 0 || cur_active[k]) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb_q[k].size() != 0 || cur_active[k]) fail_now($sformatf("dut%0d drain_timeout", k));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       b_we [4]    = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] b_addr [4]  = '{8'h30, 8'h31, 8'h30, 8'h31};
      logic [7:0] b_wdata [4] = '{8'h11, 8'h22, 8'hEE, 8'hDD};
      logic [7:0] b_exp [4]   = '{8'h11, 8'h22, 8'h11, 8'h22};
      int base_cnt;
      exp_t e;
      int n;

      rst = 1'b1;
      req_valid = '0;
      req_we = '0;
      rsp_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         req_addr[k] = '0;
         req_wdata[k] = '0;
      end
      @(negedge clk);
      check("reset req_ready", int'(req_ready[0]), 1);
      check("reset busy", int'(busy[0]), 0);
      check("reset rsp_valid", int'(rsp_valid[0]), 0);
      check("reset rsp_rdata", int'(rsp_rdata[0]), 0);
      check("reset rsp_err", int'(rsp_err[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      issue_a(1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, 1'b0);
      issue_a(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0);
      issue_a(1'b1, 8'h20, 8'h3C, 8'h3C, 1'b0, 1'b0);
      issue_a(1'b1, 8'hEF, 8'h99, 8'h99, 1'b0, 1'b0);
      issue_a(1'b0, 8'hEF, 8'h00, 8'h99, 1'b0, 1'b0);

      // Protected window: capture the old F3 contents, then confirm the write leaves them.
      drain(0);
      issue_a(1'b0, 8'hF3, 8'h00, 8'h00, 1'b0, 1'b1);
      drain(0);
      issue_a(1'b1, 8'hF3, 8'h55, 8'h00, 1'b1, 1'b0);
      issue_a(1'b0, 8'hF3, 8'h00, snapshot, 1'b0, 1'b0);
      issue_a(1'b1, 8'hF0, 8'h66, 8'h00, 1'b1, 1'b0);

      // Stalled response with a competing request held on the request port.
      drain(0);
      rsp_ready[0] = 1'b0;
      issue_a(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0);
      n = 0;
      while (!rsp_valid[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      drive_a(1'b1, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);
      base_cnt = acc_cnt[0];
      for (int i = 0; i < 5; i++) begin
         check("stall rsp_valid", int'(rsp_valid[0]), 1);
         check("stall req_ready", int'(req_ready[0]), 0);
         @(negedge clk);
      end
      check("stall no_accept", acc_cnt[0] - base_cnt, 0);
      rsp_ready[0] = 1'b1;
      accept_a();

      // Reset during the ACCESS cycle of a write must suppress it and any response.
      drain(0);
      @(negedge clk);
      drive_a(1'b1, 8'h20, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0);
      accept_a();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort busy", int'(busy[0]), 0);
      check("abort req_ready", int'(req_ready[0]), 1);
      check("abort rsp_valid", int'(rsp_valid[0]), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort no_response", int'(rsp_valid[0]), 0);
      issue_a(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 1'b0);
      issue_a(1'b0, 8'h11, 8'h00, 8'h5A, 1'b0, 1'b0);
      drain(0);

      // Zero-wait instance, valid held high across four requests.
      @(negedge clk);
      req_valid[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_we[1]    = b_we[i];
         req_addr[1]  = b_addr[i];
         req_wdata[1] = b_wdata[i];
         e.rdata = b_exp[i];
         e.err = 1'b0;
         e.capture = 1'b0;
         sb_q[1].push_back(e);
         n = 0;
         do begin
            @(posedge clk);
            n++;
         end while (!req_ready[1] && n < 10);
         if (!req_ready[1]) fail_now("dut1 accept_timeout");
         else if (i > 0) check("dut1 accept_spacing", n, 3);
         @(negedge clk);
      end
      req_valid[1] = 1'b0;
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving the number of wait-state cycles inserted before each access (legal 0..15).
REQ-002 SHALL have parameter PROT_BASE, default 8'hF0, giving the lowest write-protected address.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port o_req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port i_req_we  input  1  1 = write (M[MA] <- MD), 0 = read (MD <- M[MA]).
REQ-008 SHALL have port i_req_addr  input  8  memory address (MA).
REQ-009 SHALL have port i_req_wdata  input  8  write data (MD).
REQ-010 SHALL have port o_rsp_valid  output  1  response available.
REQ-011 SHALL have port i_rsp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port o_rsp_rdata  output  8  read data; on a write, the written data.
REQ-013 SHALL have port o_rsp_err  output  1  request was a write to a protected address.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL contain a 256 x 8 storage array, indexed by the 8-bit address.
REQ-016 SHALL implement states IDLE, WAIT, ACCESS and RESP.
REQ-017 SHALL drive o_req_ready high only in IDLE, as a combinational decode of the state.
REQ-018 SHALL accept a request on an edge where i_req_valid and o_req_ready are both high, latching we, addr and wdata at that edge.
REQ-019 SHALL ignore i_req_* outside the accepting edge, so changes after acceptance have no effect.
REQ-020 SHALL, on acceptance, go IDLE->WAIT with the wait counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0, and go IDLE->ACCESS when WAIT_CYCLES=0.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to ACCESS on the edge where the counter equals 0.
REQ-022 SHALL, in ACCESS, perform exactly one array operation and go to RESP on the next edge.
- Read: o_rsp_rdata <= M[addr].
- Write with addr < PROT_BASE: M[addr] <= wdata, o_rsp_rdata <= wdata.
REQ-023 SHALL, for a write with addr >= PROT_BASE, leave the array unchanged and set o_rsp_rdata to 8'h00 and o_rsp_err to 1.
REQ-024 SHALL clear o_rsp_err to 0 for every other request.
REQ-025 SHALL raise o_rsp_valid exactly WAIT_CYCLES+1 rising edges after the accepting edge.
REQ-026 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RESP until an edge where i_rsp_ready is high.
REQ-027 SHALL then go RESP->IDLE, with o_rsp_valid low from that edge.
REQ-028 SHALL accept the next request no earlier than the edge after the response handshake, so that at most one request is outstanding.
REQ-029 SHALL give a request presented during RESP no effect until IDLE is reached, with o_req_ready held low.
REQ-030 SHALL treat i_rsp_ready as don't-care outside RESP.
REQ-031 SHALL support back-to-back transactions with no idle-gap requirement beyond REQ-028.

Reset
REQ-032 SHALL, while i_rst is high at an edge, force state IDLE, wait counter 0, o_rsp_valid 0, o_rsp_rdata 8'h00 and o_rsp_err 0.
REQ-033 SHALL, under reset, force o_busy 0 and o_req_ready 1 from the first edge with i_rst high.
REQ-034 SHALL give i_rst priority over every transition: a reset on the ACCESS edge suppresses the array write.
REQ-035 SHALL abandon a pending request or response on reset, with no response issued for it.
REQ-036 SHALL leave array contents unchanged by reset.
REQ-037 SHALL NOT accept a request on an edge where i_rst is high.

Verification
REQ-038 SHALL cover, with WAIT_CYCLES=1: write addr 8'h10 data 8'hA5, then read 8'h10 -> read response rdata=8'hA5, err=0, o_rsp_valid rising 2 edges after acceptance.
REQ-039 SHALL cover a write to 8'hF3 data 8'h55, then a read of 8'hF3 -> write response err=1, rdata=8'h00; read returns the prior contents, unchanged.
REQ-040 SHALL cover i_rsp_ready held low for 5 cycles in RESP -> o_rsp_valid and rdata stable for all 5 cycles, o_req_ready low, and a new request held on i_req_valid is not accepted.
REQ-041 SHALL cover i_rst pulsed on the ACCESS cycle of a write of 8'h77 to 8'h20 -> IDLE next edge, no response, and a subsequent read of 8'h20 returns the old value.
REQ-042 SHALL cover WAIT_CYCLES=0 with i_rsp_ready tied high and valid held high for 4 requests -> each o_rsp_valid 1 edge after its accept, and a new accept every 3 cycles.
